// File: rtl/ysyx_24090018_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes and FSM states.
package ysyx_24090018_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size as carried in funct3[1:0]; 2'b11 is treated as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ysyx_24090018_load_ext.sv
// Combinational load alignment: picks the addressed byte/half lane and extends it.
module ysyx_24090018_load_ext
    import ysyx_24090018_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_addr_lo,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[8*i_addr_lo +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_24090018_lsu.sv
// Memory-access stage: one instruction at a time, single outstanding data-memory request,
// results held in an output register until writeback accepts them.
module ysyx_24090018_lsu
    import ysyx_24090018_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] alu_out_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic                  RegWrite_i,
    input  logic                  Mem2Reg_i,
    input  logic [4:0]            rd_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic                  req_wen_o,
    output logic [DATA_WIDTH-1:0] req_wdata_o,
    output logic [3:0]            req_wstrb_o,
    input  logic                  rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rsp_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] alu_out_o,
    output logic [DATA_WIDTH-1:0] mem_load_data_o,
    output logic                  RegWrite_o,
    output logic                  Mem2Reg_o,
    output logic [4:0]            rd_o,
    output logic                  misalign_o
);

    lsu_state_t            r_state;
    logic                  r_req_valid, r_req_wen, r_out_valid, r_is_load;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata, r_alu_out, r_load_data;
    logic [3:0]            r_req_wstrb;
    logic [1:0]            r_addr_lo;
    logic [2:0]            r_funct3;
    logic                  r_regwrite, r_mem2reg, r_misalign;
    logic [4:0]            r_rd;

    logic                  w_mem_op, w_misalign;
    logic [1:0]            w_addr_lo, w_size;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_wdata, w_ext_data;

    assign w_mem_op  = mem_read_i | mem_write_i;
    assign w_addr_lo = alu_out_i[1:0];
    assign w_size    = funct3_i[1:0];

    // A store wins when both read and write are (illegally) set.
    always_comb begin
        w_wstrb    = 4'b0000;
        w_wdata    = '0;
        w_misalign = 1'b0;
        if (w_size == SZ_HALF) begin
            w_misalign = w_addr_lo[0];
        end else if (w_size != SZ_BYTE) begin
            w_misalign = (w_addr_lo != 2'b00);
        end
        w_misalign = w_misalign & w_mem_op;
        if (mem_write_i) begin
            case (w_size)
                SZ_BYTE: begin
                    w_wstrb = 4'b0001 << w_addr_lo;
                    w_wdata = {4{store_data_i[7:0]}};
                end
                SZ_HALF: begin
                    w_wstrb = 4'b0011 << w_addr_lo;
                    w_wdata = {2{store_data_i[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = store_data_i;
                end
            endcase
        end
    end

    ysyx_24090018_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .i_rdata   (rsp_rdata_i),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_valid <= 1'b0;
            r_req_wen   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= 4'b0000;
            r_out_valid <= 1'b0;
            r_is_load   <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_funct3    <= 3'b000;
            r_alu_out   <= '0;
            r_load_data <= '0;
            r_regwrite  <= 1'b0;
            r_mem2reg   <= 1'b0;
            r_rd        <= 5'd0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_alu_out   <= alu_out_i;
                        r_load_data <= '0;
                        r_regwrite  <= RegWrite_i & ~w_misalign;
                        r_mem2reg   <= Mem2Reg_i;
                        r_rd        <= rd_i;
                        r_misalign  <= w_misalign;
                        r_is_load   <= mem_read_i & ~mem_write_i;
                        r_addr_lo   <= w_addr_lo;
                        r_funct3    <= funct3_i;
                        r_req_addr  <= {alu_out_i[ADDR_WIDTH-1:2], 2'b00};
                        r_req_wen   <= mem_write_i;
                        r_req_wdata <= w_wdata;
                        r_req_wstrb <= w_wstrb;
                        if (!w_mem_op || w_misalign) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (req_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid_i) begin
                        if (r_is_load) begin
                            r_load_data <= w_ext_data;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready_o      = (r_state == S_IDLE);
    assign req_valid_o     = r_req_valid;
    assign req_addr_o      = r_req_addr;
    assign req_wen_o       = r_req_wen;
    assign req_wdata_o     = r_req_wdata;
    assign req_wstrb_o     = r_req_wstrb;
    assign out_valid_o     = r_out_valid;
    assign alu_out_o       = r_alu_out;
    assign mem_load_data_o = r_load_data;
    assign RegWrite_o      = r_regwrite;
    assign Mem2Reg_o       = r_mem2reg;
    assign rd_o            = r_rd;
    assign misalign_o      = r_misalign;

endmodule
